imem_boot_loader: RTL and testbench

- Upstream of the single-cycle core: receives a program image as a byte stream and writes it word-by-word into instruction memory.
- Holds the core in reset (core_rst) until the whole image has loaded and its checksum matches.
- Frame format: word count (2 bytes, little-endian), then N×4 data bytes (little-endian per word), then 1 checksum byte (XOR of all data bytes).

---
 rtl/imem_boot_loader.sv | 124 ++++++++++++
 tb/tb_imem_boot_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles a framed program image into instruction
// memory words and releases core reset once the image checksum matches.
module imem_boot_loader #(
   parameter int          MAX_WORDS = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_len;
   logic [15:0] r_word_cnt;
   logic [1:0]  r_byte_idx;
   logic [7:0]  r_csum;
   logic [23:0] r_word;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_acc;
   logic [15:0] w_len_full;
   logic        w_last_word;

   assign in_ready = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                     (r_state == DATA)   || (r_state == CSUM);
   assign w_acc      = in_valid && in_ready;
   assign w_len_full = {in_data, r_len[7:0]};
   // The previous word's write pulse has always landed before the next
   // word's fourth byte, so word_cnt equals the index of the word in flight.
   assign w_last_word = (r_word_cnt == (r_len - 16'd1));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         LEN_LO: begin
            if (w_acc) w_next = LEN_HI;
         end
         LEN_HI: begin
            if (w_acc) begin
               if (w_len_full > MAX_LEN)      w_next = ERROR;
               else if (w_len_full == 16'd0)  w_next = CSUM;
               else                           w_next = DATA;
            end
         end
         DATA: begin
            if (w_acc && (r_byte_idx == 2'd3) && w_last_word)
               w_next = CSUM;
         end
         CSUM: begin
            if (w_acc) w_next = (in_data == r_csum) ? DONE : ERROR;
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= LEN_LO;
         r_len      <= 16'd0;
         r_word_cnt <= 16'd0;
         r_byte_idx <= 2'd0;
         r_csum     <= 8'd0;
         r_word     <= 24'd0;
         r_we       <= 1'b0;
         r_addr     <= BASE_ADDR;
         r_wdata    <= 32'd0;
      end else begin
         r_state <= w_next;
         r_we    <= 1'b0;
         if (r_we) r_word_cnt <= r_word_cnt + 16'd1;
         if (w_acc) begin
            unique case (r_state)
               LEN_LO: r_len[7:0]  <= in_data;
               LEN_HI: r_len[15:8] <= in_data;
               DATA: begin
                  r_csum     <= r_csum ^ in_data;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  unique case (r_byte_idx)
                     2'd0: r_word[7:0]   <= in_data;
                     2'd1: r_word[15:8]  <= in_data;
                     2'd2: r_word[23:16] <= in_data;
                     default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {in_data, r_word};
                        r_addr  <= BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign done       = (r_state == DONE);
   assign error      = (r_state == ERROR);
   assign core_rst   = (r_state != DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded bench for imem_boot_loader: expected writes are queued as
// bytes are sent and a negedge monitor pops them on each imem_we pulse.
module tb_imem_boot_loader;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   imem_boot_loader #(
      .MAX_WORDS(64),
      .BASE_ADDR(32'h0000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .core_rst(core_rst),
      .done(done),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         logic [63:0] e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== e) begin
               bad++;
               $display("FAIL write got=%h_%h exp=%h_%h",
                        imem_addr, imem_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hFF;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load(input int n, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [7:0] cs, input int maxgap);
      logic [31:0] w;
      logic [15:0] len;
      len = 16'(n);
      send(len[7:0], 0);
      send(len[15:8], 0);
      for (int i = 0; i < n; i++) begin
         w = (i == 0) ? w0 : (i == 1) ? w1 : w2;
         for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back({32'(4 * i), w});
            send(w[8*b +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
         end
      end
      send(cs, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic chk_ok(input string tag);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
   endtask

   task automatic chk_err(input string tag);
      chk({tag, "_error"}, 32'(error), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic chk_drained(input string tag);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_core_rst", 32'(core_rst), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      load(2, 32'h00500093, 32'h00A00113, 32'h0, 8'h71, 0);
      chk_ok("n2_good");
      chk_drained("n2_good");

      do_reset();
      load(2, 32'h00500093, 32'h00A00113, 32'h0, 8'h70, 0);
      chk_err("n2_badcs");
      chk_drained("n2_badcs");

      do_reset();
      send(8'h41, 0);
      chk("over_err_early", 32'(error), 32'd0);
      send(8'h00, 0);
      chk_err("oversize");
      chk_drained("oversize");

      do_reset();
      load(0, 32'h0, 32'h0, 32'h0, 8'h00, 0);
      chk_ok("n0_good");
      chk_drained("n0_good");

      do_reset();
      load(0, 32'h0, 32'h0, 32'h0, 8'h5A, 0);
      chk_err("n0_bad");
      chk_drained("n0_bad");

      do_reset();
      load(3, 32'h00500093, 32'h00A00113, 32'h002081B3, 8'h63, 0);
      chk_ok("n3_nogap");
      chk_drained("n3_nogap");

      do_reset();
      load(3, 32'h00500093, 32'h00A00113, 32'h002081B3, 8'h63, 3);
      chk_ok("n3_gaps");
      chk_drained("n3_gaps");

      do_reset();
      send(8'h02, 0);
      send(8'h00, 0);
      exp_q.push_back({32'h0, 32'h00500093});
      send(8'h93, 0);
      send(8'h00, 0);
      send(8'h50, 0);
      send(8'h00, 0);
      send(8'h13, 0);
      send(8'h01, 0);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_we", 32'(imem_we), 32'd0);
      chk("abort_addr", imem_addr, 32'h0);
      chk("abort_wdata", imem_wdata, 32'h0);
      chk("abort_core_rst", 32'(core_rst), 32'd1);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      load(1, 32'h00500093, 32'h0, 32'h0, 8'hC3, 0);
      chk_ok("abort_reload");
      chk_drained("abort_reload");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
